// File: rtl/ctrl_pipe.sv
// Pipeline control: captures the ID decode mask and carries the control fields through EX/MEM/WB.
// Latency: one cycle per stage (ID->EX 1, ->MEM 2, ->WB 3); hazard, stall and forward selects are combinational.
// Backpressure: a load-use hazard raises stall and inserts an EX bubble; ex_redirect squashes ID and overrides stall.
module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [8:0]       id_ctrl_mask,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic [1:0]       ex_alu_op,
    output logic [4:0]       ex_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_valid,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_reg_write,
    output logic             mem_mem2reg,
    output logic [4:0]       mem_rd,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic             wb_mem2reg,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_count
);

    // Decoder mask bit positions
    localparam int B_ALU_SRC   = 8;
    localparam int B_MEM2REG   = 7;
    localparam int B_REG_WRITE = 6;
    localparam int B_MEM_READ  = 5;
    localparam int B_MEM_WRITE = 4;
    localparam int B_BRANCH    = 3;
    localparam int B_JUMP      = 2;

    localparam logic [1:0]       FWD_NONE = 2'b00;
    localparam logic [1:0]       FWD_MEM  = 2'b10;
    localparam logic [1:0]       FWD_WB   = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // ID->EX stage register
    logic       ex_valid_q, ex_valid_d;
    logic [8:0] ex_mask_q,  ex_mask_d;
    logic [4:0] ex_rs1_q,   ex_rs1_d;
    logic [4:0] ex_rs2_q,   ex_rs2_d;
    logic [4:0] ex_rd_q,    ex_rd_d;

    // EX->MEM stage register
    logic       mem_valid_q,     mem_valid_d;
    logic       mem_mem_read_q,  mem_mem_read_d;
    logic       mem_mem_write_q, mem_mem_write_d;
    logic       mem_reg_write_q, mem_reg_write_d;
    logic       mem_mem2reg_q,   mem_mem2reg_d;
    logic [4:0] mem_rd_q,        mem_rd_d;

    // MEM->WB stage register
    logic       wb_valid_q,     wb_valid_d;
    logic       wb_reg_write_q, wb_reg_write_d;
    logic       wb_mem2reg_q,   wb_mem2reg_d;
    logic [4:0] wb_rd_q,        wb_rd_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic hazard;
    logic load_bubble;

    // Forward source for one EX operand; MEM wins over WB, x0 never matches
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_vld,
        input logic       m_wr,
        input logic [4:0] m_rd,
        input logic       w_vld,
        input logic       w_wr,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (m_vld && m_wr && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end else if (w_vld && w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Load-use detection; rs2 is compared for every opcode (conservative), redirect overrides stall
    always_comb begin
        hazard = id_valid && ex_valid_q && ex_mask_q[B_MEM_READ] &&
                 (ex_rd_q != 5'd0) &&
                 ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
        stall       = hazard && !ex_redirect;
        load_bubble = stall || ex_redirect || !id_valid;
    end

    // Next-state for all stage registers and the saturating stall counter
    always_comb begin
        ex_valid_d = 1'b0;
        ex_mask_d  = 9'd0;
        ex_rs1_d   = 5'd0;
        ex_rs2_d   = 5'd0;
        ex_rd_d    = 5'd0;
        if (!load_bubble) begin
            ex_valid_d = 1'b1;
            ex_mask_d  = id_ctrl_mask;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
        end

        mem_valid_d     = ex_valid_q;
        mem_mem_read_d  = ex_mask_q[B_MEM_READ];
        mem_mem_write_d = ex_mask_q[B_MEM_WRITE];
        mem_reg_write_d = ex_mask_q[B_REG_WRITE];
        mem_mem2reg_d   = ex_mask_q[B_MEM2REG];
        mem_rd_d        = ex_rd_q;

        wb_valid_d     = mem_valid_q;
        wb_reg_write_d = mem_reg_write_q;
        wb_mem2reg_d   = mem_mem2reg_q;
        wb_rd_d        = mem_rd_q;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    // Stage registers advance every edge; reset empties the whole pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_mask_q       <= 9'd0;
            ex_rs1_q        <= 5'd0;
            ex_rs2_q        <= 5'd0;
            ex_rd_q         <= 5'd0;
            mem_valid_q     <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            mem_mem_write_q <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_mem2reg_q   <= 1'b0;
            mem_rd_q        <= 5'd0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem2reg_q    <= 1'b0;
            wb_rd_q         <= 5'd0;
            stall_count_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_mask_q       <= ex_mask_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            mem_valid_q     <= mem_valid_d;
            mem_mem_read_q  <= mem_mem_read_d;
            mem_mem_write_q <= mem_mem_write_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_mem2reg_q   <= mem_mem2reg_d;
            mem_rd_q        <= mem_rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem2reg_q    <= wb_mem2reg_d;
            wb_rd_q         <= wb_rd_d;
            stall_count_q   <= stall_count_d;
        end
    end

    // EX operand forward selects from the MEM/WB stage registers
    always_comb begin
        fwd_a = fwd_sel(ex_rs1_q, mem_valid_q, mem_reg_write_q, mem_rd_q,
                        wb_valid_q, wb_reg_write_q, wb_rd_q);
        fwd_b = fwd_sel(ex_rs2_q, mem_valid_q, mem_reg_write_q, mem_rd_q,
                        wb_valid_q, wb_reg_write_q, wb_rd_q);
    end

    // Write/access controls are qualified by stage valid
    assign ex_valid      = ex_valid_q;
    assign ex_alu_src    = ex_mask_q[B_ALU_SRC];
    assign ex_branch     = ex_mask_q[B_BRANCH];
    assign ex_jump       = ex_mask_q[B_JUMP];
    assign ex_alu_op     = ex_mask_q[1:0];
    assign ex_rd         = ex_rd_q;
    assign mem_valid     = mem_valid_q;
    assign mem_mem_read  = mem_mem_read_q  & mem_valid_q;
    assign mem_mem_write = mem_mem_write_q & mem_valid_q;
    assign mem_reg_write = mem_reg_write_q & mem_valid_q;
    assign mem_mem2reg   = mem_mem2reg_q;
    assign mem_rd        = mem_rd_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q & wb_valid_q;
    assign wb_mem2reg    = wb_mem2reg_q;
    assign wb_rd         = wb_rd_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: instruction-level pipeline model plus directed programs.
// The upstream driver re-presents the ID instruction whenever the model predicts a stall.
// A second instance with a 2-bit counter covers saturation.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       v;
        logic [8:0] m;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       redir;
    } ins_t;

    localparam logic [8:0] M_R  = 9'b001000010;
    localparam logic [8:0] M_I  = 9'b101000011;
    localparam logic [8:0] M_LW = 9'b111100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [8:0] id_ctrl_mask = 9'd0;
    logic [4:0] id_rs1 = 5'd0;
    logic [4:0] id_rs2 = 5'd0;
    logic [4:0] id_rd = 5'd0;
    logic       ex_redirect = 1'b0;

    logic        stall, ex_valid, ex_alu_src, ex_branch, ex_jump;
    logic [1:0]  ex_alu_op, fwd_a, fwd_b;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem2reg;
    logic        wb_valid, wb_reg_write, wb_mem2reg;
    logic [15:0] stall_count;

    logic        s_stall, s_ex_valid, s_ex_alu_src, s_ex_branch, s_ex_jump;
    logic [1:0]  s_ex_alu_op, s_fwd_a, s_fwd_b;
    logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
    logic        s_mem_valid, s_mem_mem_read, s_mem_mem_write, s_mem_reg_write, s_mem_mem2reg;
    logic        s_wb_valid, s_wb_reg_write, s_wb_mem2reg;
    logic [1:0]  s_stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl_mask(id_ctrl_mask),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem2reg(mem_mem2reg), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem2reg(wb_mem2reg),
        .wb_rd(wb_rd), .stall_count(stall_count)
    );

    ctrl_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl_mask(id_ctrl_mask),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(s_stall), .ex_valid(s_ex_valid), .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch),
        .ex_jump(s_ex_jump), .ex_alu_op(s_ex_alu_op), .ex_rd(s_ex_rd), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .mem_valid(s_mem_valid), .mem_mem_read(s_mem_mem_read), .mem_mem_write(s_mem_mem_write),
        .mem_reg_write(s_mem_reg_write), .mem_mem2reg(s_mem_mem2reg), .mem_rd(s_mem_rd),
        .wb_valid(s_wb_valid), .wb_reg_write(s_wb_reg_write), .wb_mem2reg(s_wb_mem2reg),
        .wb_rd(s_wb_rd), .stall_count(s_stall_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: one whole instruction record per stage
    ins_t m_ex, m_mem, m_wb;
    int   m_cnt, m_cnt_s;

    function automatic bit m_stall();
        bit uses;
        uses = (m_ex.rd == id_rs1) || (m_ex.rd == id_rs2);
        return id_valid && m_ex.v && m_ex.m[5] && (m_ex.rd != 5'd0) && uses && !ex_redirect;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (m_mem.v && m_mem.m[6] && m_mem.rd != 5'd0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.v && m_wb.m[6] && m_wb.rd != 5'd0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Model advance: instructions shift one stage per edge, ID enters unless stalled/squashed/empty
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            bit st;
            st    = m_stall();
            m_wb  = m_mem;
            m_mem = m_ex;
            if (st || ex_redirect || !id_valid) m_ex = '0;
            else m_ex = '{v: 1'b1, m: id_ctrl_mask, rs1: id_rs1, rs2: id_rs2, rd: id_rd, redir: 1'b0};
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("stall",         32'(stall),         32'(m_stall()));
        chk("ex_valid",      32'(ex_valid),      32'(m_ex.v));
        chk("ex_alu_src",    32'(ex_alu_src),    32'(m_ex.m[8]));
        chk("ex_branch",     32'(ex_branch),     32'(m_ex.m[3]));
        chk("ex_jump",       32'(ex_jump),       32'(m_ex.m[2]));
        chk("ex_alu_op",     32'(ex_alu_op),     32'(m_ex.m[1:0]));
        chk("ex_rd",         32'(ex_rd),         32'(m_ex.rd));
        chk("fwd_a",         32'(fwd_a),         32'(m_fwd(m_ex.rs1)));
        chk("fwd_b",         32'(fwd_b),         32'(m_fwd(m_ex.rs2)));
        chk("mem_valid",     32'(mem_valid),     32'(m_mem.v));
        chk("mem_mem_read",  32'(mem_mem_read),  32'(m_mem.v & m_mem.m[5]));
        chk("mem_mem_write", 32'(mem_mem_write), 32'(m_mem.v & m_mem.m[4]));
        chk("mem_reg_write", 32'(mem_reg_write), 32'(m_mem.v & m_mem.m[6]));
        chk("mem_mem2reg",   32'(mem_mem2reg),   32'(m_mem.m[7]));
        chk("mem_rd",        32'(mem_rd),        32'(m_mem.rd));
        chk("wb_valid",      32'(wb_valid),      32'(m_wb.v));
        chk("wb_reg_write",  32'(wb_reg_write),  32'(m_wb.v & m_wb.m[6]));
        chk("wb_mem2reg",    32'(wb_mem2reg),    32'(m_wb.m[7]));
        chk("wb_rd",         32'(wb_rd),         32'(m_wb.rd));
        chk("stall_count",   32'(stall_count),   32'(m_cnt));
        chk("sat_count",     32'(s_stall_count), 32'(m_cnt_s));
    end

    // Upstream instruction supplier
    ins_t prog[$];
    int   pc = -1;

    function automatic ins_t ins(input logic [8:0] m, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic redir = 1'b0);
        return '{v: 1'b1, m: m, rs1: rs1, rs2: rs2, rd: rd, redir: redir};
    endfunction

    task automatic drive();
        ins_t e;
        e = '0;
        if (pc >= 0 && pc < prog.size()) e = prog[pc];
        id_valid     = e.v;
        id_ctrl_mask = e.m;
        id_rs1       = e.rs1;
        id_rs2       = e.rs2;
        id_rd        = e.rd;
        ex_redirect  = e.redir;
    endtask

    // One clock: ID is held when the model predicts a stall, otherwise the next instruction is offered
    task automatic step(output bit st);
        st = m_stall();
        @(posedge clk);
        #1;
        if (!st) pc++;
        drive();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        bit s;
        repeat (n) step(s);
    endtask

    initial begin
        bit s;
        int k;
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        drive();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_stall",     32'(stall),       32'd0);
        chk("rst_ex_valid",  32'(ex_valid),    32'd0);
        chk("rst_mem_valid", 32'(mem_valid),   32'd0);
        chk("rst_wb_valid",  32'(wb_valid),    32'd0);
        chk("rst_fwd_a",     32'(fwd_a),       32'd0);
        chk("rst_count",     32'(stall_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Straight-line R then I (I reads the R result from MEM)
        prog.delete();
        prog.push_back(ins(M_R, 5'd1, 5'd2, 5'd5));
        prog.push_back(ins(M_I, 5'd5, 5'd0, 5'd6));
        pc = -1;
        step(s);
        step(s);
        chk("t1_ex_alu_op_r", 32'(ex_alu_op), 32'd2);
        chk("t1_ex_rd",       32'(ex_rd),     32'd5);
        chk("t1_no_stall",    32'(stall),     32'd0);
        step(s);
        chk("t1_mem_reg_write", 32'(mem_reg_write), 32'd1);
        chk("t1_mem_rd",        32'(mem_rd),        32'd5);
        chk("t1_ex_alu_op_i",   32'(ex_alu_op),     32'd3);
        chk("t1_fwd_a_mem",     32'(fwd_a),         32'd2);
        step(s);
        chk("t1_wb_reg_write", 32'(wb_reg_write), 32'd1);
        chk("t1_wb_rd",        32'(wb_rd),        32'd5);
        run(3);

        // Load-use: one stall, bubble, then WB forward
        prog.delete();
        prog.push_back(ins(M_LW, 5'd1, 5'd0, 5'd7));
        prog.push_back(ins(M_R, 5'd7, 5'd2, 5'd8));
        pc = -1;
        step(s);
        step(s);
        chk("t2_stall",      32'(stall),       32'd1);
        chk("t2_count_pre",  32'(stall_count), 32'd0);
        step(s);
        chk("t2_ex_bubble",  32'(ex_valid),     32'd0);
        chk("t2_stall_off",  32'(stall),        32'd0);
        chk("t2_count",      32'(stall_count),  32'd1);
        chk("t2_mem_read",   32'(mem_mem_read), 32'd1);
        step(s);
        chk("t2_ex_valid",   32'(ex_valid), 32'd1);
        chk("t2_ex_rd",      32'(ex_rd),    32'd8);
        chk("t2_fwd_a_wb",   32'(fwd_a),    32'd1);
        run(3);

        // MEM over WB priority, then x0 producers
        prog.delete();
        prog.push_back(ins(M_R,  5'd1, 5'd2, 5'd3));
        prog.push_back(ins(M_R,  5'd1, 5'd2, 5'd3));
        prog.push_back(ins(M_R,  5'd3, 5'd3, 5'd9));
        prog.push_back(ins(M_LW, 5'd1, 5'd0, 5'd0));
        prog.push_back(ins(M_R,  5'd0, 5'd0, 5'd0));
        prog.push_back(ins(M_R,  5'd0, 5'd0, 5'd10));
        pc = -1;
        run(4);
        chk("t3_fwd_a_prio", 32'(fwd_a), 32'd2);
        chk("t3_fwd_b_prio", 32'(fwd_b), 32'd2);
        step(s);
        chk("t3_x0_no_stall", 32'(stall), 32'd0);
        run(2);
        chk("t3_x0_fwd_a", 32'(fwd_a), 32'd0);
        chk("t3_x0_fwd_b", 32'(fwd_b), 32'd0);
        run(3);

        // Redirect beats a simultaneous rs2 load-use hazard
        prog.delete();
        prog.push_back(ins(M_LW, 5'd1, 5'd0, 5'd4));
        prog.push_back(ins(M_R,  5'd1, 5'd4, 5'd12, 1'b1));
        prog.push_back(ins(M_R,  5'd1, 5'd2, 5'd11));
        pc = -1;
        step(s);
        step(s);
        chk("t4_redir_stall", 32'(stall),       32'd0);
        chk("t4_count_pre",   32'(stall_count), 32'd1);
        step(s);
        chk("t4_ex_bubble",   32'(ex_valid),    32'd0);
        chk("t4_mem_valid",   32'(mem_valid),   32'd1);
        chk("t4_mem_rd",      32'(mem_rd),      32'd4);
        chk("t4_count",       32'(stall_count), 32'd1);
        step(s);
        chk("t4_ex_next_rd",  32'(ex_rd), 32'd11);
        run(3);

        // Async reset with every stage valid, forwards active and a stall pending
        prog.delete();
        prog.push_back(ins(M_R,  5'd1,  5'd2,  5'd12));
        prog.push_back(ins(M_R,  5'd1,  5'd2,  5'd13));
        prog.push_back(ins(M_LW, 5'd13, 5'd12, 5'd14));
        prog.push_back(ins(M_R,  5'd14, 5'd0,  5'd15));
        pc = -1;
        run(4);
        chk("t6_pre_stall", 32'(stall), 32'd1);
        chk("t6_pre_fwd_a", 32'(fwd_a), 32'd2);
        chk("t6_pre_fwd_b", 32'(fwd_b), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_ex_valid",  32'(ex_valid),      32'd0);
        chk("t6_mem_valid", 32'(mem_valid),     32'd0);
        chk("t6_wb_valid",  32'(wb_valid),      32'd0);
        chk("t6_stall",     32'(stall),         32'd0);
        chk("t6_fwd_a",     32'(fwd_a),         32'd0);
        chk("t6_fwd_b",     32'(fwd_b),         32'd0);
        chk("t6_count",     32'(stall_count),   32'd0);
        chk("t6_sat_count", 32'(s_stall_count), 32'd0);
        prog.delete();
        pc = -1;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Chain of dependent loads: five stall events against a 2-bit counter
        prog.delete();
        prog.push_back(ins(M_LW, 5'd0, 5'd0, 5'd1));
        prog.push_back(ins(M_LW, 5'd1, 5'd0, 5'd2));
        prog.push_back(ins(M_LW, 5'd2, 5'd0, 5'd3));
        prog.push_back(ins(M_LW, 5'd3, 5'd0, 5'd4));
        prog.push_back(ins(M_LW, 5'd4, 5'd0, 5'd5));
        prog.push_back(ins(M_R,  5'd5, 5'd0, 5'd6));
        pc = -1;
        k = 0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            step(s);
            if (s) begin
                chk("t5_sat_seq", 32'(s_stall_count), 32'(sat_exp[k]));
                k++;
            end
        end
        chk("t5_stall_events", 32'(k), 32'd5);
        chk("t5_count16",      32'(stall_count), 32'd5);
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
